// File: rtl/mmio_timer_pkg.sv
// Shared definitions for mmio_timer: register offsets, CTRL/STATUS bit positions, FSM states.
package mmio_timer_pkg;

  localparam logic [1:0] REG_LOAD   = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int unsigned CTRL_EN_BIT     = 0;
  localparam int unsigned CTRL_AUTO_BIT   = 1;
  localparam int unsigned STATUS_DONE_BIT = 0;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic [15:0] ctrl_word(input logic en, input logic auto_rl);
    logic [15:0] w;
    w = '0;
    w[CTRL_EN_BIT]   = en;
    w[CTRL_AUTO_BIT] = auto_rl;
    return w;
  endfunction

  function automatic logic [15:0] status_word(input logic done);
    logic [15:0] w;
    w = '0;
    w[STATUS_DONE_BIT] = done;
    return w;
  endfunction

endpackage

// File: rtl/mmio_timer_tick_gen.sv
// Prescaler for mmio_timer: counts 0..PRESCALE-1 while enabled, tick high on the last count.
module tick_gen #(
  parameter int unsigned PRESCALE = 50000
) (
  input  logic Clock,
  input  logic Reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] pre;

  assign tick = enable && (pre == LAST);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      pre <= '0;
    end else if (clear) begin
      pre <= '0;
    end else if (enable) begin
      pre <= (pre == LAST) ? '0 : pre + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped countdown timer with LOAD/CTRL/COUNT/STATUS registers.
// Optional auto-reload (CTRL.AUTO) enabled by defining MMIO_TIMER_AUTORELOAD_EN.
module mmio_timer
  import mmio_timer_pkg::*;
#(
  parameter int unsigned PRESCALE = 50000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] ADDR,
  input  logic [15:0] DOUT,
  input  logic        W,
  input  logic        cs,
  output logic [15:0] rdata,
  output logic        Done
);

  state_t      state;
  logic [15:0] load_q;
  logic [15:0] count_q;
  logic        ctrl_en;
  logic        ctrl_auto;
  logic        done_q;

  logic wr, wr_load, wr_ctrl, wr_status, start, tick, expire;
  logic unused_bits;

  assign wr        = cs & W;
  assign wr_load   = wr && (ADDR[1:0] == REG_LOAD);
  assign wr_ctrl   = wr && (ADDR[1:0] == REG_CTRL);
  assign wr_status = wr && (ADDR[1:0] == REG_STATUS);
  assign start     = wr_ctrl && DOUT[CTRL_EN_BIT];
  // A CTRL write in the same cycle as a tick takes precedence over it.
  assign expire    = !wr_ctrl && (state == RUN) && tick && (count_q == '0);
  assign Done      = done_q;

  assign unused_bits = ^{ADDR[15:2], DOUT[15:1]};

  tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .Clock  (Clock),
    .Reset  (Reset),
    .clear  (start),
    .enable (state == RUN),
    .tick   (tick)
  );

`ifdef MMIO_TIMER_AUTORELOAD_EN
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      ctrl_auto <= 1'b0;
    end else if (wr_ctrl) begin
      ctrl_auto <= DOUT[CTRL_AUTO_BIT];
    end
  end
`else
  assign ctrl_auto = 1'b0;
`endif

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      load_q  <= '0;
      count_q <= '0;
      ctrl_en <= 1'b0;
      done_q  <= 1'b0;
      rdata   <= '0;
    end else begin
      case (ADDR[1:0])
        REG_LOAD:  rdata <= load_q;
        REG_CTRL:  rdata <= ctrl_word(ctrl_en, ctrl_auto);
        REG_COUNT: rdata <= count_q;
        default:   rdata <= status_word(done_q);
      endcase

      if (wr_load) begin
        load_q <= DOUT;
      end

      if (wr_ctrl) begin
        ctrl_en <= DOUT[CTRL_EN_BIT];
        if (DOUT[CTRL_EN_BIT]) begin
          state   <= RUN;
          count_q <= load_q;
        end else begin
          state <= IDLE;
        end
      end else if ((state == RUN) && tick) begin
        if (count_q != '0) begin
          count_q <= count_q - 16'd1;
        end else if (ctrl_auto) begin
          count_q <= load_q;
        end else begin
          ctrl_en <= 1'b0;
          state   <= IDLE;
        end
      end

      if (expire) begin
        done_q <= 1'b1;
      end else if (wr_status) begin
        done_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mmio_timer.sv
// Self-checking bench for mmio_timer (PRESCALE=4); covers auto-reload when MMIO_TIMER_AUTORELOAD_EN is defined.
module tb_mmio_timer;

  localparam int unsigned PRESCALE = 4;
`ifdef MMIO_TIMER_AUTORELOAD_EN
  localparam bit AUTO_OK = 1'b1;
`else
  localparam bit AUTO_OK = 1'b0;
`endif

  logic        Clock;
  logic        Reset;
  logic [15:0] ADDR;
  logic [15:0] DOUT;
  logic        W;
  logic        cs;
  logic [15:0] rdata;
  logic        Done;

  mmio_timer #(.PRESCALE(PRESCALE)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .ADDR  (ADDR),
    .DOUT  (DOUT),
    .W     (W),
    .cs    (cs),
    .rdata (rdata),
    .Done  (Done)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int n_tests = 0;
  int n_fail  = 0;
  bit armed   = 1'b0;

  // Behavioural model: timer described as "edges elapsed since start".
  logic [15:0] m_load, m_count;
  logic        m_en, m_auto, m_done, m_run;
  int          m_elapsed;
  logic [15:0] exp_rdata;
  logic        exp_done;

  function automatic logic [15:0] reg_view(input logic [1:0] a);
    case (a)
      2'd0:    return m_load;
      2'd1:    return {14'h0, m_auto, m_en};
      2'd2:    return m_count;
      default: return {15'h0, m_done};
    endcase
  endfunction

  task automatic model_reset();
    m_load = '0; m_count = '0; m_en = 1'b0; m_auto = 1'b0;
    m_done = 1'b0; m_run = 1'b0; m_elapsed = 0;
    exp_rdata = '0; exp_done = 1'b0;
  endtask

  task automatic model_step(input logic [1:0] a, input logic [15:0] d, input logic wr);
    logic tick, set_done;
    if (Reset) begin
      model_reset();
      return;
    end
    exp_rdata = reg_view(a);
    tick = 1'b0;
    set_done = 1'b0;
    if (m_run) begin
      m_elapsed++;
      tick = (m_elapsed % PRESCALE) == 0;
    end
    if (wr && a == 2'd1) begin
      m_en   = d[0];
      m_auto = AUTO_OK && d[1];
      if (d[0]) begin
        m_run = 1'b1; m_count = m_load; m_elapsed = 0;
      end else begin
        m_run = 1'b0;
      end
    end else if (tick) begin
      if (m_count > 0) m_count = m_count - 16'd1;
      else begin
        set_done = 1'b1;
        if (m_auto) m_count = m_load;
        else begin m_en = 1'b0; m_run = 1'b0; end
      end
    end
    if (wr && a == 2'd0) m_load = d;
    if (set_done) m_done = 1'b1;
    else if (wr && a == 2'd3) m_done = 1'b0;
    exp_done = m_done;
  endtask

  always @(negedge Clock) begin
    if (armed) begin
      n_tests++;
      if (rdata !== exp_rdata) begin
        n_fail++;
        $display("FAIL model_rdata t=%0t: got %h want %h", $time, rdata, exp_rdata);
      end
      n_tests++;
      if (Done !== exp_done) begin
        n_fail++;
        $display("FAIL model_done t=%0t: got %b want %b", $time, Done, exp_done);
      end
    end
  end

  task automatic lit(input string name, input logic [15:0] got, input logic [15:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic cyc(input logic [1:0] a, input logic [15:0] d, input logic w_i, input logic cs_i);
    ADDR = {4'h4, 10'h0, a};
    DOUT = d;
    W    = w_i;
    cs   = cs_i;
    @(posedge Clock);
    model_step(a, d, w_i && cs_i);
    @(negedge Clock);
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    cyc(a, d, 1'b1, 1'b1);
  endtask

  task automatic rd(input logic [1:0] a);
    cyc(a, 16'h0, 1'b0, 1'b1);
  endtask

  task automatic idle(input int n, input logic [1:0] a);
    for (int i = 0; i < n; i++) rd(a);
  endtask

  initial begin
    Reset = 1'b1; ADDR = '0; DOUT = '0; W = 1'b0; cs = 1'b0;
    model_reset();
    repeat (2) @(negedge Clock);
    lit("reset_rdata", rdata, 16'h0);
    lit("reset_done", {15'h0, Done}, 16'h0);
    Reset = 1'b0;
    armed = 1'b1;
    rd(0); lit("reset_load", rdata, 16'h0);
    rd(1); lit("reset_ctrl", rdata, 16'h0);
    rd(2); lit("reset_count", rdata, 16'h0);
    rd(3); lit("reset_status", rdata, 16'h0);

    // Writes without cs are ignored
    cyc(0, 16'h1234, 1'b1, 1'b0);
    cyc(1, 16'h0001, 1'b1, 1'b0);
    rd(0); lit("nocs_load", rdata, 16'h0);
    rd(1); lit("nocs_ctrl", rdata, 16'h0);
    wr(0, 16'd3);
    rd(0); lit("load_readback", rdata, 16'd3);

    // LOAD=3 one-shot: DONE 16 cycles after CTRL write
    wr(1, 16'd1);
    idle(15, 3); lit("oneshot_done_early", {15'h0, Done}, 16'h0);
    idle(1, 3);  lit("oneshot_done_16", {15'h0, Done}, 16'h1);
    rd(1); lit("oneshot_ctrl_cleared", rdata, 16'h0);
    rd(2); lit("oneshot_count_zero", rdata, 16'h0);
    wr(3, 16'hffff); lit("status_clear", {15'h0, Done}, 16'h0);

    // LOAD=0 expires on first tick
    wr(0, 16'd0); wr(1, 16'd1);
    idle(3, 3); lit("load0_early", {15'h0, Done}, 16'h0);
    idle(1, 3); lit("load0_tick", {15'h0, Done}, 16'h1);
    wr(3, 16'h0);

    // STATUS clear on the expiry edge: set wins
    wr(1, 16'd1);
    idle(3, 3);
    wr(3, 16'h0); lit("set_wins", {15'h0, Done}, 16'h1);
    rd(3); lit("set_wins_status", rdata, 16'h1);
    wr(3, 16'h0);

    // Stop freezes COUNT, restart reloads
    wr(0, 16'd5); wr(1, 16'd1);
    idle(5, 2);
    wr(1, 16'd0);
    idle(20, 2); lit("frozen_count", rdata, 16'd4);
    wr(1, 16'd1);
    rd(2); lit("restart_count", rdata, 16'd5);
    wr(1, 16'd0);

    // Restart while running; LOAD write in RUN leaves COUNT alone
    wr(0, 16'd2); wr(1, 16'd1);
    idle(6, 2);
    wr(1, 16'd1);
    rd(2); lit("rerun_count", rdata, 16'd2);
    idle(3, 2);
    wr(0, 16'd9);
    rd(2); lit("load_in_run_count", rdata, 16'd1);
    rd(0); lit("load_in_run_load", rdata, 16'd9);
    idle(12, 3);
    wr(1, 16'd0); wr(3, 16'h0);

`ifdef MMIO_TIMER_AUTORELOAD_EN
    wr(0, 16'd1); wr(1, 16'd3);
    idle(7, 3); lit("auto_early", {15'h0, Done}, 16'h0);
    idle(1, 3); lit("auto_done_8", {15'h0, Done}, 16'h1);
    wr(3, 16'h0); lit("auto_clear_9", {15'h0, Done}, 16'h0);
    idle(6, 3); lit("auto_still_clear", {15'h0, Done}, 16'h0);
    idle(1, 3); lit("auto_done_16", {15'h0, Done}, 16'h1);
    rd(2); lit("auto_reload_count", rdata, 16'd1);
    rd(1); lit("auto_ctrl", rdata, 16'd3);
    wr(1, 16'd0); wr(3, 16'h0);
`else
    wr(0, 16'd0); wr(1, 16'd3);
    rd(1); lit("noauto_ctrl", rdata, 16'd1);
    idle(3, 3); lit("noauto_done", {15'h0, Done}, 16'h1);
    rd(1); lit("noauto_oneshot", rdata, 16'h0);
    wr(3, 16'h0);
`endif

    // Asynchronous reset mid-count
    wr(0, 16'd3); wr(1, 16'd1);
    idle(5, 2);
    #2 Reset = 1'b1;
    model_reset();
    #1;
    lit("async_rst_rdata", rdata, 16'h0);
    lit("async_rst_done", {15'h0, Done}, 16'h0);
    @(negedge Clock);
    idle(3, 2);
    Reset = 1'b0;
    idle(30, 3); lit("post_rst_no_done", {15'h0, Done}, 16'h0);
    rd(2); lit("post_rst_count", rdata, 16'h0);
    rd(1); lit("post_rst_ctrl", rdata, 16'h0);

    armed = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
